// File: rtl/systolic_feeder_if.sv
// Load/start handshake and skewed operand outputs of the systolic feeder.
interface systolic_feeder_if #(parameter int DATAWIDTH = 8);
   logic                 load_valid;
   logic                 load_ready;
   logic                 load_sel;
   logic [3:0]           load_addr;
   logic [DATAWIDTH-1:0] load_data;
   logic                 start;
   logic                 busy;
   logic                 done;
   logic [DATAWIDTH-1:0] a0, a1, a2;
   logic [DATAWIDTH-1:0] b0, b1, b2;

   modport master (
      output load_valid, load_sel, load_addr, load_data, start,
      input  load_ready, busy, done, a0, a1, a2, b0, b1, b2
   );

   modport slave (
      input  load_valid, load_sel, load_addr, load_data, start,
      output load_ready, busy, done, a0, a1, a2, b0, b1, b2
   );
endinterface

// File: rtl/systolic_feeder.sv
// Holds two 3x3 operand matrices and streams them, row/column skewed,
// into the edge of a 3x3 output-stationary systolic array.
module systolic_feeder #(
   parameter int DATAWIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   systolic_feeder_if.slave   bus
);
   typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;
   typedef logic [DATAWIDTH-1:0] elem_t;

   state_t     state, state_n;
   logic [2:0] t, t_n;
   elem_t      ma   [9];
   elem_t      mb   [9];
   elem_t      ma_n [9];
   elem_t      mb_n [9];
   elem_t      a_q  [3];
   elem_t      b_q  [3];
   elem_t      a_n  [3];
   elem_t      b_n  [3];
   logic       wr_en;

   always_comb begin
      state_n = state;
      t_n     = t;
      case (state)
         S_IDLE:  if (bus.start) begin
                     state_n = S_FEED;
                     t_n     = 3'd0;
                  end
         S_FEED:  begin
                     t_n = t + 3'd1;
                     if (t == 3'd4) state_n = S_DRAIN;
                  end
         S_DRAIN: begin
                     t_n = t + 3'd1;
                     if (t == 3'd6) state_n = S_DONE;
                  end
         S_DONE:  begin
                     state_n = S_IDLE;
                     t_n     = 3'd0;
                  end
         default: begin
                     state_n = S_IDLE;
                     t_n     = 3'd0;
                  end
      endcase
   end

   // Writes are forwarded so a write coinciding with START feeds the first beat.
   always_comb begin
      wr_en = bus.load_valid && (state == S_IDLE) && (bus.load_addr <= 4'd8);
      ma_n  = ma;
      mb_n  = mb;
      if (wr_en) begin
         if (bus.load_sel) mb_n[bus.load_addr] = bus.load_data;
         else              ma_n[bus.load_addr] = bus.load_data;
      end
   end

   // Outputs are registered from the next t, so they appear in cycle t.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         int k;
         k      = int'(t_n) - i;
         a_n[i] = '0;
         b_n[i] = '0;
         if (state_n == S_FEED && k >= 0 && k <= 2) begin
            a_n[i] = ma_n[4'(i * 3 + k)];
            b_n[i] = mb_n[4'(k * 3 + i)];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         t     <= 3'd0;
         ma    <= '{default: '0};
         mb    <= '{default: '0};
         a_q   <= '{default: '0};
         b_q   <= '{default: '0};
      end else begin
         state <= state_n;
         t     <= t_n;
         ma    <= ma_n;
         mb    <= mb_n;
         a_q   <= a_n;
         b_q   <= b_n;
      end
   end

   assign bus.load_ready = (state == S_IDLE);
   assign bus.busy       = (state != S_IDLE);
   assign bus.done       = (state == S_DONE);
   assign bus.a0 = a_q[0];
   assign bus.a1 = a_q[1];
   assign bus.a2 = a_q[2];
   assign bus.b0 = b_q[0];
   assign bus.b1 = b_q[1];
   assign bus.b2 = b_q[2];
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench: fixed scenarios, a vector table and randomized runs against a
// matrix-level model and a behavioural 3x3 PE array.
module tb_systolic_feeder;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   systolic_feeder_if #(.DATAWIDTH(DW)) bus ();
   systolic_feeder #(.DATAWIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      int t;
      int a[3];
      int b[3];
      int d;
   } vec_t;

   int   passed = 0;
   int   total  = 0;
   int   ma_m[9];
   int   mb_m[9];
   int   acc[3][3];
   int   ar[3][3];
   int   br[3][3];
   int   cap_a[8][3];
   int   cap_b[8][3];
   int   cap_d[8];
   int   cap_acc[3][3];
   logic pe_clr = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int a_port(input int i);
      case (i)
         0: return int'(bus.a0);
         1: return int'(bus.a1);
         default: return int'(bus.a2);
      endcase
   endfunction

   function automatic int b_port(input int j);
      case (j)
         0: return int'(bus.b0);
         1: return int'(bus.b1);
         default: return int'(bus.b2);
      endcase
   endfunction

   // Operand that row i must see at beat t: element (i, t-i) while feeding.
   function automatic int exp_a(input int i, input int t);
      int k = t - i;
      if (t <= 4 && k >= 0 && k <= 2) return ma_m[i*3 + k];
      return 0;
   endfunction

   function automatic int exp_b(input int j, input int t);
      int k = t - j;
      if (t <= 4 && k >= 0 && k <= 2) return mb_m[k*3 + j];
      return 0;
   endfunction

   function automatic int prod(input int i, input int j);
      int s = 0;
      for (int k = 0; k < 3; k++) s += ma_m[i*3 + k] * mb_m[k*3 + j];
      return s;
   endfunction

   function automatic int pe_a(input int i, input int j);
      return (j == 0) ? a_port(i) : ar[i][j-1];
   endfunction

   function automatic int pe_b(input int i, input int j);
      return (i == 0) ? b_port(j) : br[i-1][j];
   endfunction

   // Output-stationary PE array: operands move right/down one PE per cycle.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            if (pe_clr) begin
               acc[i][j] <= 0;
               ar[i][j]  <= 0;
               br[i][j]  <= 0;
            end else begin
               acc[i][j] <= acc[i][j] + pe_a(i, j) * pe_b(i, j);
               ar[i][j]  <= pe_a(i, j);
               br[i][j]  <= pe_b(i, j);
            end
         end
   end

   task automatic wr(input bit sel, input int addr, input int data);
      @(negedge clk);
      bus.load_valid = 1'b1;
      bus.load_sel   = sel;
      bus.load_addr  = 4'(addr);
      bus.load_data  = DW'(data);
      @(negedge clk);
      bus.load_valid = 1'b0;
      if (addr <= 8) begin
         if (sel) mb_m[addr] = data;
         else     ma_m[addr] = data;
      end
   endtask

   task automatic run_stream(input bit w, input bit sel, input int addr, input int data,
                             input string tag);
      @(negedge clk);
      bus.start = 1'b1;
      pe_clr    = 1'b1;
      if (w) begin
         bus.load_valid = 1'b1;
         bus.load_sel   = sel;
         bus.load_addr  = 4'(addr);
         bus.load_data  = DW'(data);
      end
      @(negedge clk);
      bus.start      = 1'b0;
      pe_clr         = 1'b0;
      bus.load_valid = 1'b0;
      if (w && addr <= 8) begin
         if (sel) mb_m[addr] = data;
         else     ma_m[addr] = data;
      end
      for (int t = 0; t < 8; t++) begin
         if (t > 0) @(negedge clk);
         chk($sformatf("%s t%0d busy", tag, t), int'(bus.busy), 1);
         chk($sformatf("%s t%0d ready", tag, t), int'(bus.load_ready), 0);
         chk($sformatf("%s t%0d done", tag, t), int'(bus.done), (t == 7) ? 1 : 0);
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s t%0d A%0d", tag, t, i), a_port(i), exp_a(i, t));
            chk($sformatf("%s t%0d B%0d", tag, t, i), b_port(i), exp_b(i, t));
            cap_a[t][i] = a_port(i);
            cap_b[t][i] = b_port(i);
         end
         cap_d[t] = int'(bus.done);
         if (t == 7)
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++) begin
                  chk($sformatf("%s C%0d%0d", tag, i, j), acc[i][j], prod(i, j));
                  cap_acc[i][j] = acc[i][j];
               end
      end
      @(negedge clk);
      chk({tag, " idle busy"}, int'(bus.busy), 0);
      chk({tag, " idle done"}, int'(bus.done), 0);
      chk({tag, " idle ready"}, int'(bus.load_ready), 1);
   endtask

   vec_t tab[8];
   int   b2e[5] = '{0, 0, 3, 6, 9};
   int   b1e[5] = '{0, 2, 5, 8, 0};
   int   cexp[9] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};

   initial begin
      tab[0] = '{0, '{1, 0, 0}, '{1, 0, 0}, 0};
      tab[1] = '{1, '{2, 4, 0}, '{0, 0, 0}, 0};
      tab[2] = '{2, '{3, 5, 7}, '{0, 1, 0}, 0};
      tab[3] = '{3, '{0, 6, 8}, '{0, 0, 0}, 0};
      tab[4] = '{4, '{0, 0, 9}, '{0, 0, 1}, 0};
      tab[5] = '{5, '{0, 0, 0}, '{0, 0, 0}, 0};
      tab[6] = '{6, '{0, 0, 0}, '{0, 0, 0}, 0};
      tab[7] = '{7, '{0, 0, 0}, '{0, 0, 0}, 1};
      for (int k = 0; k < 9; k++) begin
         ma_m[k] = 0;
         mb_m[k] = 0;
      end

      bus.load_valid = 1'b0;
      bus.load_sel   = 1'b0;
      bus.load_addr  = 4'd0;
      bus.load_data  = '0;
      bus.start      = 1'b0;
      rst            = 1'b1;
      #12;
      chk("reset ready", int'(bus.load_ready), 1);
      chk("reset busy", int'(bus.busy), 0);
      chk("reset done", int'(bus.done), 0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset A%0d", i), a_port(i), 0);
         chk($sformatf("reset B%0d", i), b_port(i), 0);
      end
      @(negedge clk);
      rst = 1'b0;

      // MA = 1..9, MB = identity, checked against the vector table
      for (int k = 0; k < 9; k++) wr(1'b0, k, k + 1);
      for (int k = 0; k < 9; k++) wr(1'b1, k, (k % 4 == 0) ? 1 : 0);
      run_stream(1'b0, 1'b0, 0, 0, "ident");
      foreach (tab[n]) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("tab t%0d A%0d", tab[n].t, i), cap_a[tab[n].t][i], tab[n].a[i]);
            chk($sformatf("tab t%0d B%0d", tab[n].t, i), cap_b[tab[n].t][i], tab[n].b[i]);
         end
         chk($sformatf("tab t%0d done", tab[n].t), cap_d[tab[n].t], tab[n].d);
      end

      // MB = 1..9: column skew, and the full product on the PE array
      for (int k = 0; k < 9; k++) wr(1'b1, k, k + 1);
      run_stream(1'b0, 1'b0, 0, 0, "mb19");
      for (int t = 0; t < 5; t++) begin
         chk($sformatf("col t%0d B2", t), cap_b[t][2], b2e[t]);
         chk($sformatf("col t%0d B1", t), cap_b[t][1], b1e[t]);
      end
      for (int k = 0; k < 9; k++) chk($sformatf("pe C%0d", k), cap_acc[k/3][k%3], cexp[k]);

      // START during FEED and a write during DRAIN are both ignored
      @(negedge clk);
      bus.start = 1'b1;
      pe_clr    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      pe_clr    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("norestart t3 A0", a_port(0), exp_a(0, 3));
      chk("norestart t3 A1", a_port(1), exp_a(1, 3));
      @(negedge clk);
      @(negedge clk);
      bus.load_valid = 1'b1;
      bus.load_sel   = 1'b0;
      bus.load_addr  = 4'd0;
      bus.load_data  = DW'(8'h5a);
      chk("drain ready", int'(bus.load_ready), 0);
      chk("drain busy", int'(bus.busy), 1);
      @(negedge clk);
      bus.load_valid = 1'b0;
      @(negedge clk);
      chk("norestart done", int'(bus.done), 1);
      @(negedge clk);
      chk("norestart idle", int'(bus.busy), 0);
      run_stream(1'b0, 1'b0, 0, 0, "after_drain_wr");

      // Out-of-range addresses change nothing
      wr(1'b0, 12, 77);
      wr(1'b1, 15, 88);
      run_stream(1'b0, 1'b0, 0, 0, "bad_addr");

      // Write coincident with START feeds the first beat
      run_stream(1'b1, 1'b0, 0, 200, "coincide");
      chk("coincide A0 t0", cap_a[0][0], 200);

      for (int r = 0; r < 20; r++) begin
         int nw = $urandom_range(0, 6);
         for (int w = 0; w < nw; w++)
            wr(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255));
         run_stream(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 15), $urandom_range(0, 255), $sformatf("rnd%0d", r));
      end

      // Asynchronous reset in the middle of FEED
      @(negedge clk);
      bus.start = 1'b1;
      pe_clr    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      pe_clr    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("arst busy", int'(bus.busy), 0);
      chk("arst ready", int'(bus.load_ready), 1);
      chk("arst done", int'(bus.done), 0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("arst A%0d", i), a_port(i), 0);
         chk($sformatf("arst B%0d", i), b_port(i), 0);
      end
      for (int k = 0; k < 9; k++) begin
         ma_m[k] = 0;
         mb_m[k] = 0;
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("post_rst c%0d done", c), int'(bus.done), 0);
         chk($sformatf("post_rst c%0d busy", c), int'(bus.busy), 0);
      end
      run_stream(1'b0, 1'b0, 0, 0, "zero_stream");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
